// File: rtl/fft_cbfp_reorder_buf.sv
// CBFP FFT output stage: de-normalises bit-reversed bins (rounding shift + saturate)
// into a ping-pong bank at natural-order addresses, then streams frames out PAR bins per beat.
module fft_cbfp_reorder_buf #(
  parameter int N     = 512,
  parameter int PAR   = 16,
  parameter int IN_W  = 16,
  parameter int OUT_W = 13,
  parameter int SC_W  = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PAR*IN_W-1:0]   in_re,
  input  logic [PAR*IN_W-1:0]   in_im,
  input  logic [PAR*SC_W-1:0]   in_scale,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PAR*OUT_W-1:0]  out_re,
  output logic [PAR*OUT_W-1:0]  out_im,
  output logic                  out_last,
  output logic                  frame_ovf,
  output logic [3:0]            dbg_bank_state
);

  localparam int LOG2N = $clog2(N);
  localparam int BEATS = N / PAR;
  localparam int BW    = $clog2(BEATS);
  localparam int PB    = $clog2(PAR);

  localparam logic signed [IN_W:0] SAT_HI = signed'((IN_W+1)'((1 << (OUT_W-1)) - 1));
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

  // Valid/ready: a beat moves on a rising edge where valid & ready are both high; the
  // producer holds valid and data stable until then, and ready never depends on valid.
  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_st_e;

  bank_st_e                 st_q [2];
  bank_st_e                 st_d [2];
  logic [1:0]               ovf_q, ovf_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [BW-1:0]            wr_beat_q, wr_beat_d;
  logic [BW-1:0]            rd_beat_q, rd_beat_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     frame_ovf_q, frame_ovf_d;
  logic [PAR*OUT_W-1:0]     out_re_q, out_re_d;
  logic [PAR*OUT_W-1:0]     out_im_q, out_im_d;

  logic [OUT_W-1:0]         mem_re_q [2][N];
  logic [OUT_W-1:0]         mem_im_q [2][N];

  logic [OUT_W-1:0]         wr_re   [PAR];
  logic [OUT_W-1:0]         wr_im   [PAR];
  logic [LOG2N-1:0]         wr_addr [PAR];
  logic                     any_sat;
  logic [LOG2N-1:0]         rd_addr [PAR];
  logic [OUT_W-1:0]         rd_re   [PAR];
  logic [OUT_W-1:0]         rd_im   [PAR];
  logic                     in_fire, out_fire;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  // Returns {saturated, value}; the sum is one bit wider than the input so rounding cannot wrap.
  function automatic logic [OUT_W:0] denorm(input logic [IN_W-1:0] din, input logic [SC_W-1:0] sc);
    logic signed [IN_W:0] ext, rnd, v;
    logic [OUT_W-1:0]     val;
    logic                 sat;
    int                   r;
    r   = (int'(sc) > IN_W) ? IN_W : int'(sc);
    ext = signed'({din[IN_W-1], din});
    if (r == 0) begin
      v = ext;
    end else begin
      rnd = signed'((IN_W+1)'(1) << (r - 1));
      v   = (ext + rnd) >>> r;
    end
    sat = 1'b1;
    if (v > SAT_HI) begin
      val = SAT_HI[OUT_W-1:0];
    end else if (v < SAT_LO) begin
      val = SAT_LO[OUT_W-1:0];
    end else begin
      sat = 1'b0;
      val = v[OUT_W-1:0];
    end
    return {sat, val};
  endfunction

  assign in_ready = (st_q[wr_bank_q] == B_EMPTY) || (st_q[wr_bank_q] == B_FILL);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    logic [OUT_W:0] dn_re, dn_im;
    any_sat = 1'b0;
    for (int j = 0; j < PAR; j++) begin
      dn_re      = denorm(in_re[j*IN_W +: IN_W], in_scale[j*SC_W +: SC_W]);
      dn_im      = denorm(in_im[j*IN_W +: IN_W], in_scale[j*SC_W +: SC_W]);
      wr_re[j]   = dn_re[OUT_W-1:0];
      wr_im[j]   = dn_im[OUT_W-1:0];
      any_sat    = any_sat | dn_re[OUT_W] | dn_im[OUT_W];
      wr_addr[j] = bitrev({wr_beat_q, PB'(j)});
    end
  end

  // The two banks can never be written and read-advanced in the same cycle: the write bank
  // is EMPTY/FILL while the read bank must be FULL/DRAIN to fire.
  always_comb begin
    st_d      = st_q;
    ovf_d     = ovf_q;
    wr_bank_d = wr_bank_q;
    wr_beat_d = wr_beat_q;
    rd_bank_d = rd_bank_q;
    rd_beat_d = rd_beat_q;
    if (in_fire) begin
      ovf_d[wr_bank_q] = ovf_q[wr_bank_q] | any_sat;
      if (wr_beat_q == BW'(BEATS-1)) begin
        st_d[wr_bank_q] = B_FULL;
        wr_bank_d       = ~wr_bank_q;
        wr_beat_d       = '0;
      end else begin
        st_d[wr_bank_q] = B_FILL;
        wr_beat_d       = wr_beat_q + BW'(1);
      end
    end
    if (out_fire) begin
      if (out_last_q) begin
        st_d[rd_bank_q]  = B_EMPTY;
        ovf_d[rd_bank_q] = 1'b0;
        rd_bank_d        = ~rd_bank_q;
        rd_beat_d        = '0;
      end else begin
        st_d[rd_bank_q] = B_DRAIN;
        rd_beat_d       = rd_beat_q + BW'(1);
      end
    end
    out_valid_d = (st_d[rd_bank_d] == B_FULL) || (st_d[rd_bank_d] == B_DRAIN);
    out_last_d  = out_valid_d && (rd_beat_d == BW'(BEATS-1));
    frame_ovf_d = out_valid_d && ovf_d[rd_bank_d];
  end

  // Output register looks at next-cycle bank contents, so a frame completed this cycle
  // forwards its final writes straight into beat 0.
  always_comb begin
    out_re_d = '0;
    out_im_d = '0;
    for (int i = 0; i < PAR; i++) begin
      rd_addr[i] = {rd_beat_d, PB'(i)};
      rd_re[i]   = mem_re_q[rd_bank_d][rd_addr[i]];
      rd_im[i]   = mem_im_q[rd_bank_d][rd_addr[i]];
      for (int j = 0; j < PAR; j++) begin
        if (in_fire && (wr_bank_q == rd_bank_d) && (wr_addr[j] == rd_addr[i])) begin
          rd_re[i] = wr_re[j];
          rd_im[i] = wr_im[j];
        end
      end
      if (out_valid_d) begin
        out_re_d[i*OUT_W +: OUT_W] = rd_re[i];
        out_im_d[i*OUT_W +: OUT_W] = rd_im[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q[0]     <= B_EMPTY;
      st_q[1]     <= B_EMPTY;
      ovf_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_beat_q   <= '0;
      rd_beat_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ovf_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      st_q        <= st_d;
      ovf_q       <= ovf_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_beat_q   <= wr_beat_d;
      rd_beat_q   <= rd_beat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_ovf_q <= frame_ovf_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int j = 0; j < PAR; j++) begin
        mem_re_q[wr_bank_q][wr_addr[j]] <= wr_re[j];
        mem_im_q[wr_bank_q][wr_addr[j]] <= wr_im[j];
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign frame_ovf      = frame_ovf_q;
  assign out_re         = out_re_q;
  assign out_im         = out_im_q;
  assign dbg_bank_state = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_fft_cbfp_reorder_buf.sv
// Bench for fft_cbfp_reorder_buf: vector table, directed corner sequences and random frames
// checked against a natural-order reference model through an expected-beat queue.
module tb_fft_cbfp_reorder_buf;

  localparam int N = 512, PAR = 16, IN_W = 16, OUT_W = 13, SC_W = 5;
  localparam int BEATS = N / PAR;
  localparam int LOG2N = 9;
  localparam int BUS   = PAR * OUT_W;
  localparam int EW    = 2 + 2 * BUS;
  localparam int OMAX  = (1 << (OUT_W-1)) - 1;
  localparam int OMIN  = -(1 << (OUT_W-1));

  logic                 clk, rstn, in_valid, in_ready, out_valid, out_ready, out_last, frame_ovf;
  logic [PAR*IN_W-1:0]  in_re, in_im;
  logic [PAR*SC_W-1:0]  in_scale;
  logic [BUS-1:0]       out_re, out_im;
  logic [3:0]           dbg_bank_state;

  fft_cbfp_reorder_buf #(.N(N), .PAR(PAR), .IN_W(IN_W), .OUT_W(OUT_W), .SC_W(SC_W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .frame_ovf(frame_ovf), .dbg_bank_state(dbg_bank_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- shared state ----------------
  int             n_tests = 0, n_fail = 0;
  logic [EW-1:0]  exp_q[$];
  int             stim_re[N], stim_im[N], stim_sc[N];
  int             cap_re[N], cap_im[N];
  int             cap_ovf = 0;
  int             rdy_mode = 1;
  int             rx_beats = 0, acc_beats = 0, in_stalls = 0;
  int             stream_base = -1, stream_first = 0, last_hs = 0;
  int             in_last_cyc[$], out_last_cyc[$];

  typedef struct {int re; int im; int sc; int exp_re; int exp_im;} vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bitrev_i(input int a);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if ((a & (1 << b)) != 0) r |= 1 << (LOG2N-1-b);
    return r;
  endfunction

  function automatic int floor_div(input int x, input int d);
    int q = x / d;
    if ((x % d != 0) && (x < 0)) q--;
    return q;
  endfunction

  function automatic int scale_bin(input int x, input int sc, output bit sat);
    int r, v;
    r = (sc > IN_W) ? IN_W : sc;
    if (r == 0) v = x;
    else v = floor_div(x + (1 << (r-1)), 1 << r);
    sat = 1'b0;
    if (v > OMAX) begin v = OMAX; sat = 1'b1; end
    else if (v < OMIN) begin v = OMIN; sat = 1'b1; end
    return v;
  endfunction

  task automatic model_frame();
    int nat_re[N], nat_im[N];
    bit ovf, s;
    logic [BUS-1:0] rb, ib;
    ovf = 1'b0;
    for (int a = 0; a < N; a++) begin
      nat_re[bitrev_i(a)] = scale_bin(stim_re[a], stim_sc[a], s); ovf |= s;
      nat_im[bitrev_i(a)] = scale_bin(stim_im[a], stim_sc[a], s); ovf |= s;
    end
    for (int m = 0; m < BEATS; m++) begin
      for (int j = 0; j < PAR; j++) begin
        rb[j*OUT_W +: OUT_W] = OUT_W'(nat_re[m*PAR+j]);
        ib[j*OUT_W +: OUT_W] = OUT_W'(nat_im[m*PAR+j]);
      end
      exp_q.push_back({(m == BEATS-1), ovf, rb, ib});
    end
  endtask

  // kind 0: random, 1: impulse, 2: rounding/saturation table
  task automatic fill_frame(input int kind);
    int amp;
    amp = ($urandom_range(0, 1) == 1) ? 32767 : 3000;
    for (int a = 0; a < N; a++) begin
      stim_re[a] = 0; stim_im[a] = 0; stim_sc[a] = 0;
      if (kind == 0) begin
        stim_re[a] = int'($urandom_range(0, 2*amp)) - amp;
        stim_im[a] = int'($urandom_range(0, 2*amp)) - amp;
        stim_sc[a] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      end
    end
    if (kind == 1) begin stim_re[1] = 64; stim_sc[1] = 2; end
    if (kind == 2) begin
      for (int i = 0; i < 10; i++) begin
        stim_re[5+41*i] = tbl[i].re; stim_im[5+41*i] = tbl[i].im; stim_sc[5+41*i] = tbl[i].sc;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge; every beat is presented at a negedge and accepted on the next posedge.
  task automatic send_frame(input int kind, input int gap_pct);
    int w;
    fill_frame(kind);
    model_frame();
    for (int k = 0; k < BEATS; k++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        for (int j = 0; j < PAR; j++) begin
          in_re[j*IN_W +: IN_W] = IN_W'($urandom); in_im[j*IN_W +: IN_W] = IN_W'($urandom);
          in_scale[j*SC_W +: SC_W] = SC_W'($urandom);
        end
        @(negedge clk);
      end
      in_valid = 1'b1;
      for (int j = 0; j < PAR; j++) begin
        in_re[j*IN_W +: IN_W]    = IN_W'(stim_re[k*PAR+j]);
        in_im[j*IN_W +: IN_W]    = IN_W'(stim_im[k*PAR+j]);
        in_scale[j*SC_W +: SC_W] = SC_W'(stim_sc[k*PAR+j]);
      end
      w = 0;
      while (!in_ready) begin
        in_stalls++; w++;
        if (w > 3000) begin
          n_tests++; n_fail++;
          $display("FAIL in_ready_timeout: beat %0d waited %0d cycles, required < 3000", k, w);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      acc_beats++;
      if (k == BEATS-1) in_last_cyc.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 5000) begin @(negedge clk); t++; end
    check(name, int'(t < 5000), 1);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] hold_v, got, e;
  bit            hold_pend = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      hold_pend = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hold_pend) begin
        n_tests++;
        if (!out_valid || ({out_last, frame_ovf, out_re, out_im} !== hold_v)) begin
          n_fail++;
          $display("FAIL hold: out_valid=%0b data %h, required valid=1 data %h", out_valid,
                   {out_last, frame_ovf, out_re, out_im}, hold_v);
        end
      end
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (out_valid && out_ready) begin
        got = {out_last, frame_ovf, out_re, out_im};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got %h, required no beat", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL beat %0d: got %h expected %h", rx_beats, got, e);
          end
        end
        for (int j = 0; j < PAR; j++) begin
          cap_re[(rx_beats % BEATS)*PAR+j] = int'(signed'(out_re[j*OUT_W +: OUT_W]));
          cap_im[(rx_beats % BEATS)*PAR+j] = int'(signed'(out_im[j*OUT_W +: OUT_W]));
        end
        if (out_last) begin cap_ovf = int'(frame_ovf); out_last_cyc.push_back(cyc); end
        if (rx_beats == stream_base) stream_first = cyc;
        last_hs = cyc;
        rx_beats++;
      end
      hold_pend = out_valid && !out_ready;
      hold_v    = {out_last, frame_ovf, out_re, out_im};
    end
  end

  // ---------------- test sequence ----------------
  int nz, t, base;
  initial begin
    tbl[0] = '{6, -6, 2, 2, -1};
    tbl[1] = '{5000, -5000, 0, 4095, -4096};
    tbl[2] = '{-1, 1, 31, 0, 0};
    tbl[3] = '{7, -7, 1, 4, -3};
    tbl[4] = '{-32768, 32767, 3, -4096, 4095};
    tbl[5] = '{4095, -4096, 0, 4095, -4096};
    tbl[6] = '{32767, -32768, 16, 0, 0};
    tbl[7] = '{100, -100, 5, 3, -3};
    tbl[8] = '{1, -1, 1, 1, 0};
    tbl[9] = '{-2, 3, 1, -1, 2};

    rstn = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_scale = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_frame_ovf", int'(frame_ovf), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_zero", int'(out_re == '0 && out_im == '0), 1);
    check("rst_bank_state", int'(dbg_bank_state), 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    // impulse: beat 0 lane 1 lands in natural bin 256 (output beat 16 lane 0)
    send_frame(1, 0);
    wait_drain("imp_drain");
    check("imp_bin256", cap_re[256], 16);
    nz = 0;
    for (int n = 0; n < N; n++) if ((n != 256 && cap_re[n] != 0) || cap_im[n] != 0) nz++;
    check("imp_other_zero", nz, 0);
    check("imp_ovf", cap_ovf, 0);

    // rounding / saturation table
    send_frame(2, 0);
    wait_drain("tbl_drain");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tbl%0d_re", i), cap_re[bitrev_i(5+41*i)], tbl[i].exp_re);
      check($sformatf("tbl%0d_im", i), cap_im[bitrev_i(5+41*i)], tbl[i].exp_im);
    end
    check("tbl_ovf", cap_ovf, 1);

    // random frames with input gaps and random out_ready
    rdy_mode = 2;
    repeat (3) send_frame(0, 20);
    wait_drain("rand_drain");

    // backpressure: both banks fill, then the input stalls
    rdy_mode = 0; acc_beats = 0;
    fork
      repeat (3) send_frame(0, 0);
      begin
        repeat (100) @(negedge clk);
        check("bp_accepted", acc_beats, 2*BEATS);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        rdy_mode = 2;
      end
    join
    wait_drain("bp_drain");

    // streaming: back-to-back frames, no output gaps, fill/drain meet in the same cycle
    rdy_mode = 1; in_stalls = 0; stream_base = rx_beats;
    in_last_cyc.delete(); out_last_cyc.delete();
    repeat (4) send_frame(0, 0);
    wait_drain("stream_drain");
    check("stream_span", last_hs - stream_first, 4*BEATS - 1);
    check("stream_in_stalls", in_stalls, 0);
    check("stream_latency", stream_first, (in_last_cyc.size() > 0) ? in_last_cyc[0] + 1 : -1);
    check("simul_fill_drain", (in_last_cyc.size() > 1) ? in_last_cyc[1] : -1,
          (out_last_cyc.size() > 0) ? out_last_cyc[0] : -2);
    check("stream_last_spacing", (out_last_cyc.size() > 3) ? out_last_cyc[3] - out_last_cyc[2] : -1, BEATS);
    stream_base = -1;

    // reset in the middle of a drain, then a clean frame
    base = rx_beats;
    send_frame(0, 0);
    t = 0;
    while (rx_beats < base + 5 && t < 2000) begin @(negedge clk); t++; end
    check("mid_drain_reached", int'(rx_beats >= base + 5), 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_last", int'(out_last), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_bank_state", int'(dbg_bank_state), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1; rx_beats = 0;
    @(negedge clk);
    rdy_mode = 2;
    send_frame(0, 10);
    wait_drain("post_rst_drain");
    check("post_rst_beats", rx_beats, BEATS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
